// File: rtl/tic_tac_toe_pkg.sv
// Shared encodings, scan tables and FSM state type for the tic-tac-toe computer opponent.
package tic_tac_toe_pkg;

    localparam logic [1:0] EMPTY    = 2'b00;
    localparam logic [1:0] PLAYER   = 2'b01;
    localparam logic [1:0] COMPUTER = 2'b10;

    localparam logic [1:0] WHO_NONE     = 2'b00;
    localparam logic [1:0] WHO_PLAYER   = 2'b01;
    localparam logic [1:0] WHO_COMPUTER = 2'b10;

    // Rows, then columns, then the two diagonals.
    localparam logic [3:0] LINE_TABLE [8][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    // Centre, corners, edges.
    localparam logic [3:0] PREF_ORDER [9] = '{
        4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN_WIN,
        ST_SCAN_BLOCK,
        ST_SCAN_PREF,
        ST_ISSUE,
        ST_REJECT
    } ai_state_t;

endpackage

// File: rtl/tic_tac_toe_ai_if.sv
// Move interface between the game (master) and the computer opponent (slave).
interface tic_tac_toe_ai_if;
    logic       turn_req;
    logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
    logic [1:0] who;
    logic [3:0] computer_position;
    logic       pc;
    logic       busy;
    logic       no_move;

    modport master (
        output turn_req, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, who,
        input  computer_position, pc, busy, no_move
    );

    modport slave (
        input  turn_req, pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, who,
        output computer_position, pc, busy, no_move
    );
endinterface

// File: rtl/ttt_line_eval.sv
// Flags a line holding two cells of the given mark plus one empty cell, and names that empty cell.
import tic_tac_toe_pkg::*;

module ttt_line_eval (
    input  logic [1:0] cell_a,
    input  logic [1:0] cell_b,
    input  logic [1:0] cell_c,
    input  logic [1:0] mark,
    output logic       hit,
    output logic [1:0] empty_slot
);
    logic a_m, b_m, c_m, a_e, b_e, c_e;

    assign a_m = (cell_a == mark);
    assign b_m = (cell_b == mark);
    assign c_m = (cell_c == mark);
    assign a_e = (cell_a == EMPTY);
    assign b_e = (cell_b == EMPTY);
    assign c_e = (cell_c == EMPTY);

    assign hit = (a_m & b_m & c_e) | (a_m & c_m & b_e) | (b_m & c_m & a_e);
    // Only meaningful when hit is set, in which case exactly one cell is empty.
    assign empty_slot = a_e ? 2'd0 : (b_e ? 2'd1 : 2'd2);
endmodule

// File: rtl/tic_tac_toe_ai.sv
// Computer opponent: snapshots the board, scans win/block/preference one step per cycle, strobes the move.
import tic_tac_toe_pkg::*;

// state         | meaning
// ST_IDLE       | waiting for turn_req
// ST_SCAN_WIN   | one line per cycle, looking for two COMPUTER + one EMPTY
// ST_SCAN_BLOCK | one line per cycle, looking for two PLAYER + one EMPTY
// ST_SCAN_PREF  | one preference cell per cycle, first EMPTY wins
// ST_ISSUE      | pc held high PC_HOLD cycles with computer_position stable
// ST_REJECT     | game already decided or board full; pulse no_move
module tic_tac_toe_ai #(
    parameter int PC_HOLD = 5
) (
    input logic             clk,
    input logic             rst,
    tic_tac_toe_ai_if.slave bus
);
    localparam logic [3:0] HOLD_LOAD = 4'(PC_HOLD - 1);

    ai_state_t  state, state_nxt;
    logic [1:0] snap [9];
    logic [1:0] cells_in [9];
    logic       snap_load;
    logic [3:0] idx, idx_nxt;
    logic [3:0] hold_cnt, hold_cnt_nxt;
    logic [3:0] position, position_nxt;
    logic       pc_q, pc_nxt;
    logic       no_move_q, no_move_nxt;

    logic [3:0] cell_a_idx, cell_b_idx, cell_c_idx, slot_cell, pref_cell;
    logic [1:0] mark;
    logic       hit;
    logic [1:0] empty_slot;

    assign cells_in[0] = bus.pos1;
    assign cells_in[1] = bus.pos2;
    assign cells_in[2] = bus.pos3;
    assign cells_in[3] = bus.pos4;
    assign cells_in[4] = bus.pos5;
    assign cells_in[5] = bus.pos6;
    assign cells_in[6] = bus.pos7;
    assign cells_in[7] = bus.pos8;
    assign cells_in[8] = bus.pos9;

    assign cell_a_idx = LINE_TABLE[idx[2:0]][0];
    assign cell_b_idx = LINE_TABLE[idx[2:0]][1];
    assign cell_c_idx = LINE_TABLE[idx[2:0]][2];
    assign pref_cell  = PREF_ORDER[idx];
    assign mark       = (state == ST_SCAN_BLOCK) ? PLAYER : COMPUTER;
    assign slot_cell  = (empty_slot == 2'd0) ? cell_a_idx :
                        (empty_slot == 2'd1) ? cell_b_idx : cell_c_idx;

    ttt_line_eval u_line_eval (
        .cell_a     (snap[cell_a_idx]),
        .cell_b     (snap[cell_b_idx]),
        .cell_c     (snap[cell_c_idx]),
        .mark       (mark),
        .hit        (hit),
        .empty_slot (empty_slot)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 9; i++) snap[i] <= EMPTY;
        end else if (snap_load) begin
            for (int i = 0; i < 9; i++) snap[i] <= cells_in[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            hold_cnt  <= '0;
            position  <= '0;
            pc_q      <= 1'b0;
            no_move_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            hold_cnt  <= hold_cnt_nxt;
            position  <= position_nxt;
            pc_q      <= pc_nxt;
            no_move_q <= no_move_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        hold_cnt_nxt = hold_cnt;
        position_nxt = position;
        pc_nxt       = pc_q;
        no_move_nxt  = 1'b0;
        snap_load    = 1'b0;
        case (state)
            ST_IDLE: begin
                pc_nxt = 1'b0;
                if (bus.turn_req) begin
                    if (bus.who == WHO_NONE) begin
                        snap_load = 1'b1;
                        idx_nxt   = '0;
                        state_nxt = ST_SCAN_WIN;
                    end else begin
                        state_nxt = ST_REJECT;
                    end
                end
            end
            ST_SCAN_WIN, ST_SCAN_BLOCK: begin
                if (hit) begin
                    position_nxt = slot_cell;
                    pc_nxt       = 1'b1;
                    hold_cnt_nxt = HOLD_LOAD;
                    state_nxt    = ST_ISSUE;
                end else if (idx == 4'd7) begin
                    idx_nxt   = '0;
                    state_nxt = (state == ST_SCAN_WIN) ? ST_SCAN_BLOCK : ST_SCAN_PREF;
                end else begin
                    idx_nxt = idx + 4'd1;
                end
            end
            ST_SCAN_PREF: begin
                if (snap[pref_cell] == EMPTY) begin
                    position_nxt = pref_cell;
                    pc_nxt       = 1'b1;
                    hold_cnt_nxt = HOLD_LOAD;
                    state_nxt    = ST_ISSUE;
                end else if (idx == 4'd8) begin
                    state_nxt = ST_REJECT;
                end else begin
                    idx_nxt = idx + 4'd1;
                end
            end
            ST_ISSUE: begin
                if (hold_cnt == 4'd0) begin
                    pc_nxt    = 1'b0;
                    state_nxt = ST_IDLE;
                end else begin
                    hold_cnt_nxt = hold_cnt - 4'd1;
                end
            end
            ST_REJECT: begin
                no_move_nxt = 1'b1;
                state_nxt   = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.computer_position = position;
    assign bus.pc                = pc_q;
    assign bus.busy              = (state != ST_IDLE);
    assign bus.no_move           = no_move_q;

endmodule

// File: tb/tb_tic_tac_toe_ai.sv
// Directed bench for tic_tac_toe_ai: move latency, choice, strobe width, rejects and async reset.
module tb_tic_tac_toe_ai;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    localparam int WINDOW = 40;

    tic_tac_toe_ai_if bus ();
    tic_tac_toe_ai_if bus1 ();

    tic_tac_toe_ai #(.PC_HOLD(5)) dut  (.clk(clk), .rst(rst), .bus(bus));
    tic_tac_toe_ai #(.PC_HOLD(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // The PC_HOLD=1 instance sees exactly the same stimulus.
    assign bus1.turn_req = bus.turn_req;
    assign bus1.who      = bus.who;
    assign bus1.pos1 = bus.pos1;
    assign bus1.pos2 = bus.pos2;
    assign bus1.pos3 = bus.pos3;
    assign bus1.pos4 = bus.pos4;
    assign bus1.pos5 = bus.pos5;
    assign bus1.pos6 = bus.pos6;
    assign bus1.pos7 = bus.pos7;
    assign bus1.pos8 = bus.pos8;
    assign bus1.pos9 = bus.pos9;

    always #5 clk = ~clk;

    // Cell 0 in the top two bits, cell 8 in the bottom two.
    localparam logic [17:0] B_EMPTY  = 18'b00_00_00_00_00_00_00_00_00;
    localparam logic [17:0] B_WIN    = 18'b10_10_00_01_01_00_00_00_00;
    localparam logic [17:0] B_BLOCK  = 18'b01_00_10_00_01_00_00_00_00;
    localparam logic [17:0] B_CORNER = 18'b00_00_00_00_01_00_00_00_00;
    localparam logic [17:0] B_FULL   = 18'b10_01_10_10_01_01_01_10_10;

    logic [17:0] board;

    int         m_pc_first, m_pc_width, m_pc_rises, m_nm_first, m_nm_count;
    int         m_pc1_first, m_pc1_width;
    logic [3:0] m_pos;
    bit         m_pos_moved;
    logic       m_busy_after_nm;

    task automatic drive_pos(input logic [17:0] b);
        bus.pos1 = b[17:16];
        bus.pos2 = b[15:14];
        bus.pos3 = b[13:12];
        bus.pos4 = b[11:10];
        bus.pos5 = b[9:8];
        bus.pos6 = b[7:6];
        bus.pos7 = b[5:4];
        bus.pos8 = b[3:2];
        bus.pos9 = b[1:0];
    endtask

    task automatic load_board(input logic [17:0] b);
        board = b;
        drive_pos(b);
    endtask

    // Raise turn_req so that it is sampled at the next rising edge (edge N); returns #1 after N.
    task automatic do_request();
        @(negedge clk);
        bus.turn_req = 1'b1;
        @(posedge clk);
        #1;
        bus.turn_req = 1'b0;
    endtask

    // Issues a request and records what both instances do for WINDOW edges after edge N.
    task automatic request_and_watch(input bit disturb);
        logic prev_pc;
        m_pc_first = -1; m_pc_width = 0; m_pc_rises = 0;
        m_nm_first = -1; m_nm_count = 0;
        m_pc1_first = -1; m_pc1_width = 0;
        m_pos = 4'hx; m_pos_moved = 1'b0; m_busy_after_nm = 1'bx;
        prev_pc = 1'b0;
        do_request();
        for (int step = 1; step <= WINDOW; step++) begin
            @(posedge clk);
            #1;
            if (disturb && step >= 3 && step <= 10) begin
                bus.turn_req = step[0];
                drive_pos(18'($urandom));
            end
            if (disturb && step == 11) begin
                bus.turn_req = 1'b0;
                drive_pos(board);
            end
            if (bus.pc) begin
                m_pc_width++;
                if (!prev_pc) begin
                    m_pc_rises++;
                    if (m_pc_first < 0) begin
                        m_pc_first = step;
                        m_pos = bus.computer_position;
                    end
                end else if (bus.computer_position !== m_pos) begin
                    m_pos_moved = 1'b1;
                end
            end
            prev_pc = bus.pc;
            if (bus1.pc) begin
                m_pc1_width++;
                if (m_pc1_first < 0) m_pc1_first = step;
            end
            if (bus.no_move) begin
                m_nm_count++;
                if (m_nm_first < 0) m_nm_first = step;
            end
            if (m_nm_first >= 0 && step == m_nm_first + 1) m_busy_after_nm = bus.busy;
        end
    endtask

    task automatic test_reset();
        bus.turn_req = 1'b0;
        bus.who = 2'b00;
        load_board(B_WIN);
        rst = 1'b0;
        #12;
        checks++; if (bus.pc !== 1'b0) begin failures++; $display("FAIL reset_pc got=%b want=0", bus.pc); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        checks++; if (bus.no_move !== 1'b0) begin failures++; $display("FAIL reset_no_move got=%b want=0", bus.no_move); end
        checks++; if (bus.computer_position !== 4'd0) begin failures++; $display("FAIL reset_position got=%0d want=0", bus.computer_position); end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_win();
        load_board(B_WIN);
        request_and_watch(1'b0);
        checks++; if (m_pc_first !== 1) begin failures++; $display("FAIL win_latency got=%0d want=1", m_pc_first); end
        checks++; if (m_pos !== 4'd2) begin failures++; $display("FAIL win_position got=%0d want=2", m_pos); end
        checks++; if (m_pc_width !== 5) begin failures++; $display("FAIL win_pc_width got=%0d want=5", m_pc_width); end
        checks++; if (m_pos_moved !== 1'b0) begin failures++; $display("FAIL win_position_stable got=%b want=0", m_pos_moved); end
        checks++; if (m_nm_count !== 0) begin failures++; $display("FAIL win_no_move got=%0d want=0", m_nm_count); end
        checks++; if (bus.computer_position !== 4'd2) begin failures++; $display("FAIL win_position_held got=%0d want=2", bus.computer_position); end
    endtask

    task automatic test_block();
        load_board(B_BLOCK);
        request_and_watch(1'b0);
        checks++; if (m_pc_first !== 15) begin failures++; $display("FAIL block_latency got=%0d want=15", m_pc_first); end
        checks++; if (m_pos !== 4'd8) begin failures++; $display("FAIL block_position got=%0d want=8", m_pos); end
        checks++; if (m_pc_rises !== 1) begin failures++; $display("FAIL block_pc_rises got=%0d want=1", m_pc_rises); end
    endtask

    task automatic test_pref();
        load_board(B_EMPTY);
        request_and_watch(1'b0);
        checks++; if (m_pc_first !== 17) begin failures++; $display("FAIL centre_latency got=%0d want=17", m_pc_first); end
        checks++; if (m_pos !== 4'd4) begin failures++; $display("FAIL centre_position got=%0d want=4", m_pos); end
        load_board(B_CORNER);
        request_and_watch(1'b0);
        checks++; if (m_pc_first !== 18) begin failures++; $display("FAIL corner_latency got=%0d want=18", m_pc_first); end
        checks++; if (m_pos !== 4'd0) begin failures++; $display("FAIL corner_position got=%0d want=0", m_pos); end
    endtask

    task automatic test_full_board();
        load_board(B_FULL);
        request_and_watch(1'b0);
        checks++; if (m_nm_first !== 26) begin failures++; $display("FAIL full_no_move_latency got=%0d want=26", m_nm_first); end
        checks++; if (m_nm_count !== 1) begin failures++; $display("FAIL full_no_move_width got=%0d want=1", m_nm_count); end
        checks++; if (m_pc_rises !== 0) begin failures++; $display("FAIL full_pc_rises got=%0d want=0", m_pc_rises); end
        checks++; if (m_busy_after_nm !== 1'b0) begin failures++; $display("FAIL full_busy_after got=%b want=0", m_busy_after_nm); end
    endtask

    task automatic test_reject();
        load_board(B_EMPTY);
        bus.who = 2'b01;
        request_and_watch(1'b0);
        checks++; if (m_nm_first !== 1) begin failures++; $display("FAIL reject_no_move_latency got=%0d want=1", m_nm_first); end
        checks++; if (m_nm_count !== 1) begin failures++; $display("FAIL reject_no_move_width got=%0d want=1", m_nm_count); end
        checks++; if (m_pc_rises !== 0) begin failures++; $display("FAIL reject_pc_rises got=%0d want=0", m_pc_rises); end
        bus.who = 2'b00;
    endtask

    task automatic test_robust();
        load_board(B_EMPTY);
        request_and_watch(1'b1);
        checks++; if (m_pc_first !== 17) begin failures++; $display("FAIL robust_latency got=%0d want=17", m_pc_first); end
        checks++; if (m_pos !== 4'd4) begin failures++; $display("FAIL robust_position got=%0d want=4", m_pos); end
        checks++; if (m_pc_rises !== 1) begin failures++; $display("FAIL robust_single_move got=%0d want=1", m_pc_rises); end
    endtask

    task automatic test_pc_hold1();
        load_board(B_WIN);
        request_and_watch(1'b0);
        checks++; if (m_pc1_first !== 1) begin failures++; $display("FAIL hold1_latency got=%0d want=1", m_pc1_first); end
        checks++; if (m_pc1_width !== 1) begin failures++; $display("FAIL hold1_pc_width got=%0d want=1", m_pc1_width); end
    endtask

    task automatic test_mid_reset();
        // Position is 2 from the previous win; reset lands in SCAN_BLOCK.
        load_board(B_BLOCK);
        do_request();
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL scan_reset_busy got=%b want=0", bus.busy); end
        checks++; if (bus.computer_position !== 4'd0) begin failures++; $display("FAIL scan_reset_position got=%0d want=0", bus.computer_position); end
        @(negedge clk);
        rst = 1'b1;
        load_board(B_WIN);
        do_request();
        @(posedge clk);
        #1;
        checks++; if (bus.pc !== 1'b1) begin failures++; $display("FAIL issue_pre_reset_pc got=%b want=1", bus.pc); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus.pc !== 1'b0) begin failures++; $display("FAIL issue_reset_pc got=%b want=0", bus.pc); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL issue_reset_busy got=%b want=0", bus.busy); end
        checks++; if (bus.computer_position !== 4'd0) begin failures++; $display("FAIL issue_reset_position got=%0d want=0", bus.computer_position); end
        @(negedge clk);
        rst = 1'b1;
        load_board(B_EMPTY);
        request_and_watch(1'b0);
        checks++; if (m_pc_first !== 17) begin failures++; $display("FAIL post_reset_latency got=%0d want=17", m_pc_first); end
        checks++; if (m_pos !== 4'd4) begin failures++; $display("FAIL post_reset_position got=%0d want=4", m_pos); end
    endtask

    initial begin
        test_reset();
        test_win();
        test_block();
        test_pref();
        test_full_board();
        test_reject();
        test_robust();
        test_pc_hold1();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
